// File: rtl/mac_pipe_sequencer.sv
// Sequencer for a 4-lane multiply/add-tree datapath with a wide result accumulator.
module mac_pipe_sequencer #(
  parameter int unsigned W   = 16,
  parameter int unsigned AW  = 24,
  parameter int unsigned CW  = 8,
  parameter int unsigned LAT = 2
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            start,
  input  logic [CW-1:0]   len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*W-1:0]  in_data,
  input  logic [4*W-1:0]  in_weight,
  output logic [4*W-1:0]  dp_data,
  output logic [4*W-1:0]  dp_weight,
  input  logic [W-1:0]    dp_sum,
  output logic [AW-1:0]   result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            busy,
  output logic            overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [LAT-1:0] TAIL_ONLY = LAT'(1) << (LAT - 1);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   issued;
  logic [LAT-1:0]  vpipe;
  logic [AW-1:0]   acc;
  logic            ovf;
  logic            fire;
  logic            tail;
  logic            launch;
  logic [AW:0]     acc_sum;

  // in_ready kept outside the FSM block so fire does not loop back into it.
  assign in_ready = (state == RUN) && (issued < len_q);
  assign fire     = in_valid && in_ready;
  assign tail     = vpipe[LAT-1];
  assign launch   = (state == IDLE) && start;
  assign acc_sum  = {1'b0, acc} + (AW+1)'(dp_sum);

  assign result   = acc;
  assign overflow = ovf;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx     = state;
    dp_data      = '0;
    dp_weight    = '0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fire) begin
          dp_data   = in_data;
          dp_weight = in_weight;
          if (issued == len_q - CW'(1)) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (vpipe == TAIL_ONLY) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state  <= IDLE;
      len_q  <= '0;
      issued <= '0;
      vpipe  <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        len_q  <= len;
        issued <= '0;
        vpipe  <= '0;
        acc    <= '0;
        ovf    <= 1'b0;
      end else begin
        vpipe <= (vpipe << 1) | LAT'(fire);
        if (fire) begin
          issued <= issued + 1'b1;
        end
        if (tail) begin
          acc <= acc_sum[AW-1:0];
          if (acc_sum[AW]) begin
            ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe_sequencer.sv
// Scoreboard bench for mac_pipe_sequencer with a two-stage datapath model.
module tb_mac_pipe_sequencer;

  localparam int unsigned W   = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned CW  = 8;
  localparam int unsigned LAT = 2;

  logic            clk = 1'b0;
  logic            rest;
  logic            start;
  logic [CW-1:0]   len;
  logic            in_valid;
  logic            in_ready;
  logic [4*W-1:0]  in_data;
  logic [4*W-1:0]  in_weight;
  logic [4*W-1:0]  dp_data;
  logic [4*W-1:0]  dp_weight;
  logic [W-1:0]    dp_sum;
  logic [AW-1:0]   result;
  logic            result_valid;
  logic            result_ready;
  logic            busy;
  logic            overflow;

  typedef struct packed {
    logic [AW-1:0] res;
    logic          ov;
  } exp_t;

  exp_t            exp_q[$];
  logic [4*W-1:0]  gd[16];
  logic [4*W-1:0]  gw[16];
  int unsigned     checks = 0;
  int unsigned     errors = 0;

  logic [W-1:0]    prod[4] = '{default: '0};
  logic [W-1:0]    sum_q   = '0;

  mac_pipe_sequencer #(.W(W), .AW(AW), .CW(CW), .LAT(LAT)) dut (
    .clk          (clk),
    .rest         (rest),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_weight    (in_weight),
    .dp_data      (dp_data),
    .dp_weight    (dp_weight),
    .dp_sum       (dp_sum),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Datapath: products registered, then W-bit sum registered; left unreset so
  // any in-flight junk would reach the sequencer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      prod[i] <= W'(dp_data[i*W +: W] * dp_weight[i*W +: W]);
    end
    sum_q <= prod[0] + prod[1] + prod[2] + prod[3];
  end
  assign dp_sum = sum_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] gsum(input logic [4*W-1:0] d, input logic [4*W-1:0] w);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = s + W'(d[i*W +: W] * w[i*W +: W]);
    end
    return s;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_rdy"}, in_ready, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_res"}, result, 0);
    check({tag, "_dpd"}, dp_data, 0);
    check({tag, "_dpw"}, dp_weight, 0);
  endtask

  task automatic run_job(input int n, input bit rnd, input logic [63:0] vpat, input int hold);
    int              acc_cnt;
    int              last;
    int              rise;
    longint unsigned total;
    exp_t            e;
    logic [AW-1:0]   held;
    bit              fire_e;
    logic [4*W-1:0]  d;
    logic [4*W-1:0]  w;
    total = 0;
    for (int g = 0; g < n; g++) begin
      total += longint'(gsum(gd[g], gw[g]));
    end
    e.res = total[AW-1:0];
    e.ov  = (total >= (64'd1 << AW));
    exp_q.push_back(e);

    @(posedge clk); #1;
    start        = 1'b1;
    len          = CW'(n);
    in_valid     = 1'b0;
    result_ready = (hold == 0);
    @(negedge clk);
    check("busy_c0", busy, 0);

    acc_cnt = 0;
    last    = 0;
    rise    = -1;
    for (int c = 1; c <= 300 && rise < 0; c++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : vpat[(c-1) % 64];
      d         = gd[acc_cnt % 16];
      w         = gw[acc_cnt % 16];
      in_data   = d;
      in_weight = w;
      fire_e    = in_valid && (acc_cnt < n);
      @(negedge clk);
      check("in_ready", in_ready, acc_cnt < n);
      check("dp_data", dp_data, fire_e ? d : '0);
      check("dp_weight", dp_weight, fire_e ? w : '0);
      if (fire_e) begin
        acc_cnt++;
        last = c;
      end
      if (result_valid) rise = c;
    end
    in_valid = 1'b0;

    if (rise < 0) begin
      check("rv_timeout", 0, 1);
    end else begin
      check("rv_cycle", rise, (n == 0) ? 1 : last + int'(LAT) + 1);
      check("sb_nonempty", exp_q.size() > 0, 1);
      e = exp_q.pop_front();
      check("result", result, e.res);
      check("overflow", overflow, e.ov);
      check("busy_done", busy, 1);
      held = result;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        start        = 1'b1;
        len          = 8'd3;
        result_ready = 1'b0;
        @(negedge clk);
        check("hold_rv", result_valid, 1);
        check("hold_res", result, held);
        check("hold_ovf", overflow, e.ov);
        check("hold_rdy", in_ready, 0);
      end
      if (hold > 0) begin
        @(posedge clk); #1;
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        check("hs_rv", result_valid, 1);
      end
      @(posedge clk); #1;
      result_ready = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_rv", result_valid, 0);
      check("idle_res", result, held);
    end
  endtask

  task automatic reset_midjob();
    for (int g = 0; g < 4; g++) begin
      gd[g] = pack4(16'd3, 16'd9, 16'd11, 16'd7);
      gw[g] = pack4(16'd5, 16'd2, 16'd4, 16'd6);
    end
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd4;
    @(posedge clk); #1;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = gd[0];
    in_weight = gw[0];
    @(posedge clk); #1;
    rest = 1'b1;
    @(posedge clk); #1;
    rest     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_res2", result, 0);
    check("rst_mid_busy2", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rest         = 1'b1;
    start        = 1'b1;
    len          = 8'd5;
    in_valid     = 1'b0;
    in_data      = '0;
    in_weight    = '0;
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("reset");
    end
    @(posedge clk); #1;
    rest  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    gd[0] = pack4(16'd1, 16'd2, 16'd3, 16'd4);
    gw[0] = pack4(16'd5, 16'd6, 16'd7, 16'd8);
    run_job(1, 1'b0, '1, 0);

    for (int g = 0; g < 3; g++) begin
      gd[g] = pack4(16'd1, 16'd1, 16'd1, 16'd1);
      gw[g] = pack4(16'd1, 16'd1, 16'd1, 16'd1);
    end
    run_job(3, 1'b0, 64'h15, 0);

    run_job(0, 1'b0, '0, 5);

    for (int g = 0; g < 2; g++) begin
      gd[g] = pack4(16'h8000, 16'd0, 16'd0, 16'd0);
      gw[g] = pack4(16'd1, 16'd0, 16'd0, 16'd0);
    end
    run_job(2, 1'b0, '1, 0);

    gd[0] = pack4(16'd1, 16'd0, 16'd0, 16'd0);
    gw[0] = pack4(16'd1, 16'd0, 16'd0, 16'd0);
    run_job(1, 1'b0, '1, 0);

    reset_midjob();
    gd[0] = pack4(16'd2, 16'd0, 16'd0, 16'd0);
    gw[0] = pack4(16'd5, 16'd0, 16'd0, 16'd0);
    run_job(1, 1'b0, '1, 0);

    for (int j = 0; j < 6; j++) begin
      for (int g = 0; g < 16; g++) begin
        gd[g] = {$urandom, $urandom};
        gw[g] = {$urandom, $urandom};
      end
      run_job(int'($urandom_range(1, 12)), 1'b1, '0, int'($urandom_range(0, 2)));
    end

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_pipe_sequencer.md
# mac_pipe_sequencer

Controller for the 4-lane pipelined multiply/add-tree datapath (four W-bit products, two register stages, W-bit sum). It accepts a dot-product job of `len` operand groups and streams groups into the datapath through a valid/ready interface. It tracks in-flight groups with a valid pipe matched to the datapath latency and accumulates the returned sums into a wider accumulator. It then presents the final result on a valid/ready output.

## Interface
- `W`, 16, lane data/weight width and datapath sum width.
- `AW`, 24, accumulator/result width; must satisfy AW ≥ W.
- `CW`, 8, job length counter width; max `len` = 2^CW − 1.
- `LAT`, 2, datapath latency in clock edges from operand presentation to valid `dp_sum`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rest`  in  1  reset, synchronous, active-high; shared with the datapath.
- `start`  in  1  job launch; sampled only in IDLE.
- `len`  in  CW  groups in job; sampled with `start`.
- `in_valid`  in  1  operand group available.
- `in_ready`  out  1  sequencer accepts group this cycle.
- `in_data`  in  4*W  lane data, lane i at bits [i*W +: W].
- `in_weight`  in  4*W  lane weights, same packing.
- `dp_data`  out  4*W  to datapath data lanes.
- `dp_weight`  out  4*W  to datapath weight lanes.
- `dp_sum`  in  W  datapath output sum.
- `result`  out  AW  accumulated dot product.
- `result_valid`  out  1  result held valid.
- `result_ready`  in  1  consumer takes result.
- `busy`  out  1  high in any state other than IDLE.
- `overflow`  out  1  sticky per job; accumulator carried out of AW bits.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1, `len`≠0 → clear accumulator, `overflow`, issue counter, and valid pipe; latch `len`; go to RUN.
  - `start`=1, `len`=0 → clear accumulator and `overflow`; go to DONE.
- RUN:
  - `in_ready` = 1 while issued count < latched `len`.
  - Handshake fires when `in_valid && in_ready`: `dp_data`/`dp_weight` = `in_data`/`in_weight` combinationally, issue counter increments, and a 1 enters the valid pipe.
  - No handshake → `dp_data`/`dp_weight` driven to 0 and a 0 enters the valid pipe.
  - When the handshake that issues the last group fires → go to DRAIN.
- DRAIN:
  - `in_ready`=0; operands are zeros.
  - Go to DONE on the edge where the valid pipe holds exactly one set bit at its tail and that sum is accumulated.
- Accumulation (all states): when the valid pipe tail bit is 1, accumulator += zero-extended `dp_sum`, modulo 2^AW. A carry out of AW bits sets `overflow`. Bubble sums are never added.
- DONE:
  - `result_valid`=1; `result` and `overflow` hold stable.
  - `result_ready`=1 → IDLE. `result` keeps its value until the next job start.
- `start` outside IDLE is ignored.
- `in_valid` while `in_ready`=0 is ignored; the data is not consumed.
- Reset values: `in_ready`=0, `result`=0, `result_valid`=0, `busy`=0, `overflow`=0, `dp_data`=0, `dp_weight`=0; state IDLE, counter 0, valid pipe all 0.
- Reset mid-job: in-flight groups are discarded with no accumulation, and the job is abandoned. The first legal `start` is in the cycle after `rest` deasserts.

## Timing
- Valid pipe is LAT bits deep. A group presented in cycle t has its sum sampled at the end of cycle t+LAT.
- `start` sampled at the end of cycle 0 → RUN and `in_ready`=1 in cycle 1.
- With no input bubbles, groups are accepted in cycles 1..L and `result_valid` rises in cycle L+LAT+1, i.e. L+3 with default LAT.
- `len`=0: `result_valid`=1 in cycle 1 with `result`=0.
- Each input bubble delays `result_valid` by one cycle.
- Back-to-back jobs: earliest next `start` is the cycle after the `result_ready` handshake, once state is IDLE.
- Throughput: one group per cycle in RUN.

## Test plan
- Reset, no stimulus → all outputs 0, `busy`=0; `start` pulsed while `rest`=1 → no effect.
- `len`=1; data {1,2,3,4}, weights {5,6,7,8} continuous → `result`=70 and `result_valid`=1 in cycle 4. With `result_ready`=1, IDLE in cycle 5.
- `len`=3, all lanes 1×1, `in_valid` toggled 1,0,1,0,1 → exactly 3 groups accepted; `result`=12; `result_valid` in cycle 8; bubbles not accumulated.
- `len`=0 → `result_valid` in cycle 1, `result`=0. Hold `result_ready`=0 for 5 cycles while pulsing `start` → `result` stable and `start` ignored.
- `AW`=16: `len`=2, each group sum 0x8000 → `result`=0x0000, `overflow`=1. The next job with sum 1 → `overflow`=0 and `result`=1.
- `rest` asserted in cycle 2 of a `len`=4 job → next cycle IDLE with all outputs 0. A following `len`=1 job with sum 10 returns `result`=10, uncontaminated.
